// File: rtl/hdu_pkg.sv
// Shared decode helpers for the hazard scoreboard: RV32 opcode constants,
// forwarding-select encoding and operand-usage decode.
package hdu_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R || opcode == OP_S || opcode == OP_B);
  endfunction

  // Stores and branches are the only formats without a destination register.
  function automatic logic writes_rd(input logic [6:0] opcode);
    return !(opcode == OP_S || opcode == OP_B);
  endfunction

endpackage

// File: rtl/hdu_scoreboard.sv
// Pending-register scoreboard for variable-latency ops: per-register busy
// bits, a saturating outstanding-op counter and the full flag.
module hdu_scoreboard
  import hdu_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MAX_PENDING = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   issue,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic                   done,
  input  logic [REG_AW-1:0]      done_rd,
  output logic [2**REG_AW-1:0]   pending,
  output logic                   sb_full
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam int CNT_W    = $clog2(MAX_PENDING + 1);

  logic [NUM_REGS-1:0] pending_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                issue_v;
  logic                done_v;

  assign issue_v = issue && (issue_rd != '0);
  assign done_v  = done && (done_rd != '0);

  always_comb begin
    pending_d = pending;
    count_d   = count_q;
    // Clear before set: a same-cycle done to the issuing register retires the older op.
    if (done_v)  pending_d[done_rd]  = 1'b0;
    if (issue_v) pending_d[issue_rd] = 1'b1;
    if (issue_v && !done_v && count_q != CNT_W'(MAX_PENDING))
      count_d = count_q + 1'b1;
    else if (done_v && !issue_v && count_q != '0)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pending <= '0;
      count_q <= '0;
    end else begin
      pending <= pending_d;
      count_q <= count_d;
    end
  end

  assign sb_full = (count_q == CNT_W'(MAX_PENDING));

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the forwarding pipeline: stalls, redirect flushes, EX
// forwarding and a long-op scoreboard. HDU_PERF_CNT_EN adds perf counters.
module hazard_scoreboard
  import hdu_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       instr_id,
  input  logic [31:0]       instr_ex,
  input  logic [31:0]       instr_mem,
  input  logic [31:0]       instr_wb,
  input  logic              rd_wren_ex,
  input  logic              rd_wren_mem,
  input  logic              rd_wren_wb,
  input  logic              is_load_ex,
  input  logic              pc_sel_ex,
  input  logic              lop_id,
  input  logic              lop_issue,
  input  logic              lop_done,
  input  logic [REG_AW-1:0] lop_done_rd,
  output logic              i_reset_pc,
  output logic              i_reset_if,
  output logic              i_reset_id,
  output logic              i_reset_ex,
  output logic              i_reset_mem,
  output logic              i_enable_pc,
  output logic              i_enable_if,
  output logic              i_enable_id,
  output logic              i_enable_ex,
  output logic              i_enable_mem,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic              sb_full
`ifdef HDU_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);

  localparam int NUM_REGS = 2**REG_AW;

  logic [REG_AW-1:0]   rs1_id, rs2_id, rd_id;
  logic [REG_AW-1:0]   rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic                use_rs1, use_rs2, wr_rd;
  logic                load_use, sb_hit, waw, capacity, stall, hold;
  logic [NUM_REGS-1:0] pending;
  logic [3:0]          flush_cnt;
  logic                unused_bits;

  assign rs1_id = instr_id[15 +: REG_AW];
  assign rs2_id = instr_id[20 +: REG_AW];
  assign rd_id  = instr_id[7 +: REG_AW];
  assign rs1_ex = instr_ex[15 +: REG_AW];
  assign rs2_ex = instr_ex[20 +: REG_AW];
  assign rd_ex  = instr_ex[7 +: REG_AW];
  assign rd_mem = instr_mem[7 +: REG_AW];
  assign rd_wb  = instr_wb[7 +: REG_AW];

  assign unused_bits = ^{instr_id, instr_ex, instr_mem, instr_wb};

  // x0 is folded into the usage flags so no check below can match it.
  assign use_rs1 = uses_rs1(instr_id[6:0]) && (rs1_id != '0);
  assign use_rs2 = uses_rs2(instr_id[6:0]) && (rs2_id != '0);
  assign wr_rd   = writes_rd(instr_id[6:0]) && (rd_id != '0);

  hdu_scoreboard #(
    .REG_AW      (REG_AW),
    .MAX_PENDING (MAX_PENDING)
  ) u_scoreboard (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .issue    (lop_issue),
    .issue_rd (rd_ex),
    .done     (lop_done),
    .done_rd  (lop_done_rd),
    .pending  (pending),
    .sb_full  (sb_full)
  );

  assign load_use = is_load_ex && rd_wren_ex && (rd_ex != '0) &&
                    ((use_rs1 && rs1_id == rd_ex) || (use_rs2 && rs2_id == rd_ex));
  assign sb_hit   = (use_rs1 && pending[rs1_id]) || (use_rs2 && pending[rs2_id]);
  assign waw      = wr_rd && pending[rd_id];
  assign capacity = lop_id && sb_full;
  assign stall    = load_use || sb_hit || waw || capacity;
  // A redirect squashes the stalled ID instruction, so it overrides the stall.
  assign hold     = i_reset && stall && !pc_sel_ex;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      flush_cnt <= '0;
    else if (pc_sel_ex)
      flush_cnt <= 4'(FLUSH_CYCLES - 1);
    else if (flush_cnt != '0)
      flush_cnt <= flush_cnt - 1'b1;
  end

  assign i_reset_pc  = i_reset;
  assign i_reset_if  = i_reset && !pc_sel_ex && (flush_cnt == '0);
  assign i_reset_id  = i_reset && !pc_sel_ex;
  assign i_reset_ex  = i_reset && !pc_sel_ex && !stall;
  assign i_reset_mem = i_reset;

  assign i_enable_pc  = !hold;
  assign i_enable_if  = !hold;
  assign i_enable_id  = !hold;
  assign i_enable_ex  = 1'b1;
  assign i_enable_mem = 1'b1;

  function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] rs,
                                        input logic mem_wr, input logic [REG_AW-1:0] mem_rd,
                                        input logic wb_wr,  input logic [REG_AW-1:0] wb_rd);
    if (rs == '0)                  return FWD_RF;
    if (mem_wr && mem_rd == rs)    return FWD_MEM;
    if (wb_wr && wb_rd == rs)      return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_rs1_sel = i_reset ? fwd_pick(rs1_ex, rd_wren_mem, rd_mem, rd_wren_wb, rd_wb) : FWD_RF;
  assign fwd_rs2_sel = i_reset ? fwd_pick(rs2_ex, rd_wren_mem, rd_mem, rd_wren_wb, rd_wb) : FWD_RF;

`ifdef HDU_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall)     stall_cycles <= stall_cycles + 32'd1;
      if (pc_sel_ex) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule
